fb_frame_ctrl: RTL and testbench
================================

# fb_frame_ctrl

Frame-level sequencer and display-side address scheduler for the camera frame buffer. It gates OV7670 capture writes so that capture only starts and stops on frame boundaries, and arbitrates between live capture, a single-shot snapshot and a frozen image. It also turns OLED raster coordinates into frame-buffer read addresses and delivers a registered 16-bit RGB565 colour, with a background colour outside the image area. It sits between the capture block, the frame buffer and the OLED video driver, all clocked on `oclk`.

## Interface
Parameters:
- `IMG_COLS`, 80: image width in pixels.
- `IMG_ROWS`, 60: image height in pixels.
- `ADDR_W`, 13: frame-buffer address width.
- `DATA_W`, 16: pixel width, RGB565.
- `BG_COLOR`, 16'hC020: colour output outside the image area.

Ports:
- `oclk`, in, 1: system clock, 25 MHz.
- `rst`, in, 1: reset. Synchronous, active-high, clock `oclk`.
- `cfg_done`, in, 1: camera configuration finished (level).
- `cam_vsync`, in, 1: raw OV7670 vsync, asynchronous.
- `cap_we_in`, in, 1: write strobe from the capture block.
- `cap_addr_in`, in, ADDR_W: write address from the capture block.
- `freeze`, in, 1: level. 1 means stop at the end of the current frame.
- `snap`, in, 1: one-cycle pulse. Capture exactly one frame, then freeze.
- `fb_we`, out, 1: gated write enable to the frame buffer.
- `x`, in, 7: OLED row.
- `y`, in, 7: OLED column.
- `next_pixel`, in, 1: OLED pixel-advance pulse.
- `fb_raddr`, out, ADDR_W: frame-buffer read address.
- `fb_rdata`, in, DATA_W: frame-buffer read data, 1-cycle latency.
- `color`, out, 16: pixel colour to the OLED.
- `state`, out, 2: current FSM state.
- `frame_cnt`, out, 8: count of completed captured frames.
- `short_frame`, out, 1: sticky flag. The last captured frame had a pixel count ≠ IMG_COLS*IMG_ROWS.

## Operation
- `cam_vsync` passes through a 2-FF synchronizer. A rising edge on the synchronized signal gives `fs`, a one-cycle frame-boundary pulse.
- FSM states:
  - IDLE=0: leave when `cfg_done`=1, go to ARM.
  - ARM=1: wait for `fs`. On `fs`, go to CAPTURE.
  - CAPTURE=2: on `fs`, frame complete. If `freeze`=1 or snap pending, go to FROZEN. Otherwise stay in CAPTURE.
  - FROZEN=3: on `fs` with `freeze`=0 and no snap pending, go to ARM. On a `snap` pulse, set snap pending and go to ARM.
- `snap` in ARM or CAPTURE sets snap pending. Snap pending clears on entry to FROZEN.
- `cfg_done` falling to 0 in any state returns the FSM to IDLE on the next cycle.
- `fb_we` = `cap_we_in` AND (state==CAPTURE), computed combinationally. The write address and data go straight from the capture block to the frame buffer.
- Pixel counter (ADDR_W+1 bits):
  - Clears on every `fs` and increments on every gated write.
  - On `fs` in CAPTURE: `frame_cnt` increments, wrapping 255→0. `short_frame` is set if the count ≠ IMG_COLS*IMG_ROWS and cleared otherwise.
- Display path:
  - in_img = (x < IMG_ROWS) && (y < IMG_COLS).
  - `fb_raddr` is registered: x*IMG_COLS + y when in_img, otherwise 0. The multiply is a constant multiply, done as shift-add.
  - `in_img` is delayed two cycles to align with `fb_rdata`.
  - `color` is registered: `fb_rdata` when the delayed in_img is 1, otherwise BG_COLOR.
- `next_pixel` is used only to count pixels for debug and has no effect on addressing. Reading is continuous.

## Timing
- Reset values: state=IDLE, `fb_we`=0, `fb_raddr`=0, `color`=BG_COLOR, `frame_cnt`=0, `short_frame`=0, snap pending=0, synchronizer flops=0.
- `fs` is asserted 3 cycles after the raw `cam_vsync` rising edge.
- A state change takes effect on the clock edge that samples `fs`. `fb_we` therefore stops no later than the first cycle after the boundary, so no partial frame is written.
- Display latency: x/y change to `color` valid is 3 cycles. x/y must stay stable for at least 3 cycles before the OLED driver samples `color`.
- If `fs` and `snap` fall in the same cycle while in FROZEN, `snap` wins: go to ARM with snap pending set.
- If `fs` and `cfg_done` falling happen in the same cycle, go to IDLE.
- Reset mid-frame: the state forces to IDLE and `fb_we` drops in the same cycle that reset is sampled.

## Test plan
- Reset, `cfg_done`=1, three vsync pulses each with 4800 writes → ARM, then CAPTURE; `frame_cnt`=2; `short_frame`=0; `fb_we` is 0 during the pre-first-`fs` frame.
- In CAPTURE, raise `freeze` mid-frame → writes continue to the frame end, then FROZEN with `fb_we`=0. Drop `freeze` → ARM at the next `fs`, then CAPTURE at the following `fs`.
- In FROZEN, pulse `snap` → exactly one frame of 4800 writes, then FROZEN; `frame_cnt` +1.
- Frame with only 4700 writes → `short_frame`=1. Next full frame → 0.
- x=0,y=0 → `fb_raddr`=0. x=59,y=79 → 4799. x=60,y=0 → `color`=16'hC020 after 3 cycles. In-image `fb_rdata`=16'h1234 → `color`=16'h1234 after 3 cycles.
- Drop `cfg_done` during CAPTURE → IDLE and `fb_we`=0 next cycle. Drive 256 frames → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/fb_frame_ctrl_if.sv
// fb_frame_ctrl_if: capture, frame-buffer and OLED-side signals of the frame controller
//   capture side : cfg_done, cam_vsync, cap_we_in, cap_addr_in, freeze, snap -> fb_we
//   display side : x, y, next_pixel, fb_rdata -> fb_raddr, color
//   status       : state, frame_cnt, short_frame
//   slave modport is the controller; master modport is everything around it
interface fb_frame_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              cfg_done;
  logic              cam_vsync;
  logic              cap_we_in;
  logic [ADDR_W-1:0] cap_addr_in;
  logic              freeze;
  logic              snap;
  logic              fb_we;
  logic [6:0]        x;
  logic [6:0]        y;
  logic              next_pixel;
  logic [ADDR_W-1:0] fb_raddr;
  logic [DATA_W-1:0] fb_rdata;
  logic [15:0]       color;
  logic [1:0]        state;
  logic [7:0]        frame_cnt;
  logic              short_frame;
  modport master (
    output cfg_done, cam_vsync, cap_we_in, cap_addr_in, freeze, snap, x, y, next_pixel, fb_rdata,
    input  fb_we, fb_raddr, color, state, frame_cnt, short_frame
  );
  modport slave (
    input  cfg_done, cam_vsync, cap_we_in, cap_addr_in, freeze, snap, x, y, next_pixel, fb_rdata,
    output fb_we, fb_raddr, color, state, frame_cnt, short_frame
  );
endinterface

// File: rtl/fb_frame_ctrl.sv
// fb_frame_ctrl: frame-boundary capture gating (live/snapshot/freeze) and OLED read-address/colour scheduling
//   oclk, rst : clock and synchronous active-high reset
//   bus       : fb_frame_ctrl_if.slave (capture gating, frame-buffer read port, OLED colour, status)
module fb_frame_ctrl #(
  parameter int          IMG_COLS = 80,
  parameter int          IMG_ROWS = 60,
  parameter int          ADDR_W   = 13,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] BG_COLOR = 16'hC020
) (
  input logic           oclk,
  input logic           rst,
  fb_frame_ctrl_if.slave bus
);
  localparam logic [1:0]      IDLE      = 2'd0;
  localparam logic [1:0]      ARM       = 2'd1;
  localparam logic [1:0]      CAPTURE   = 2'd2;
  localparam logic [1:0]      FROZEN    = 2'd3;
  localparam logic [6:0]      COLS      = 7'(IMG_COLS);
  localparam logic [6:0]      ROWS      = 7'(IMG_ROWS);
  localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(IMG_COLS * IMG_ROWS);
  logic [1:0]        st, nxt;
  logic [2:0]        vs;
  logic              fs, snap_pend, short_r, in_img;
  logic [ADDR_W:0]   pix;
  logic [7:0]        fc;
  logic [15:0]       pix_dbg;
  logic [1:0]        in_d;
  logic [ADDR_W-1:0] raddr, raddr_n;
  logic [15:0]       color_r;
  // vs[1:0] is the 2-FF synchronizer, vs[2] the previous synchronized value; fs is registered,
  // landing 3 cycles after the raw vsync edge
  always_ff @(posedge oclk) begin
    if (rst) begin
      vs <= '0;
      fs <= 1'b0;
    end else begin
      vs <= {vs[1:0], bus.cam_vsync};
      fs <= vs[1] & ~vs[2];
    end
  end
  // a snap pulse in FROZEN beats a simultaneous fs; losing cfg_done beats everything
  assign nxt = !bus.cfg_done ? IDLE :
               st == IDLE    ? ARM :
               st == ARM     ? (fs ? CAPTURE : ARM) :
               st == CAPTURE ? ((fs && (bus.freeze || snap_pend)) ? FROZEN : CAPTURE) :
               (bus.snap || (fs && !bus.freeze && !snap_pend)) ? ARM : FROZEN;
  // rst gates fb_we directly so a reset mid-frame stops writes in the very cycle it is sampled
  assign bus.fb_we = bus.cap_we_in && st == CAPTURE && !rst;
  always_ff @(posedge oclk) begin
    if (rst) begin
      st        <= IDLE;
      snap_pend <= 1'b0;
      pix       <= '0;
      fc        <= '0;
      short_r   <= 1'b0;
      pix_dbg   <= '0;
    end else begin
      st        <= nxt;
      snap_pend <= nxt != IDLE && !(nxt == FROZEN && st != FROZEN) && (snap_pend || (bus.snap && st != IDLE));
      pix       <= fs ? '0 : pix + (ADDR_W+1)'(bus.fb_we);
      fc        <= (fs && st == CAPTURE) ? fc + 8'd1 : fc;
      short_r   <= (fs && st == CAPTURE) ? pix != FRAME_PIX : short_r;
      pix_dbg   <= pix_dbg + 16'(bus.next_pixel);
    end
  end
  assign in_img = bus.x < ROWS && bus.y < COLS;
  // x*IMG_COLS + y as a shift-add over the set bits of the column count
  always_comb begin
    raddr_n = ADDR_W'(bus.y);
    for (int i = 0; i < 7; i++) raddr_n = COLS[i] ? raddr_n + (ADDR_W'(bus.x) << i) : raddr_n;
  end
  // in_d[1] lines up with fb_rdata for the address registered two cycles earlier
  always_ff @(posedge oclk) begin
    if (rst) begin
      raddr   <= '0;
      in_d    <= '0;
      color_r <= BG_COLOR;
    end else begin
      raddr   <= in_img ? raddr_n : '0;
      in_d    <= {in_d[0], in_img};
      color_r <= in_d[1] ? 16'(bus.fb_rdata) : BG_COLOR;
    end
  end
  assign bus.fb_raddr    = raddr;
  assign bus.color       = color_r;
  assign bus.state       = st;
  assign bus.frame_cnt   = fc;
  assign bus.short_frame = short_r;
endmodule

// File: tb/tb_fb_frame_ctrl.sv
// tb_fb_frame_ctrl: directed checks of capture gating, freeze/snap sequencing, short-frame flag, frame counter wrap and display path
module tb_fb_frame_ctrl;
  logic oclk = 1'b0;
  logic rst  = 1'b1;
  int   cmp  = 0;
  int   err  = 0;
  int   wcnt;
  fb_frame_ctrl_if #(.ADDR_W(13), .DATA_W(16)) bus ();
  fb_frame_ctrl #(.IMG_COLS(80), .IMG_ROWS(60), .ADDR_W(13), .DATA_W(16), .BG_COLOR(16'hC020)) dut (
    .oclk(oclk),
    .rst (rst),
    .bus (bus)
  );
  always #5 oclk = ~oclk;

  task automatic writes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      bus.cap_we_in   = 1'b1;
      bus.cap_addr_in = 13'(i);
      #1;
      if (bus.fb_we) cnt++;
      @(negedge oclk);
    end
    bus.cap_we_in = 1'b0;
  endtask

  task automatic vsync();
    bus.cam_vsync = 1'b1;
    repeat (5) @(negedge oclk);
    bus.cam_vsync = 1'b0;
    repeat (4) @(negedge oclk);
  endtask

  task automatic test_reset();
    bus.cfg_done = 0; bus.cam_vsync = 0; bus.cap_we_in = 1; bus.cap_addr_in = '0;
    bus.freeze = 0; bus.snap = 0; bus.x = 7'd0; bus.y = 7'd0; bus.next_pixel = 0; bus.fb_rdata = 16'h0;
    rst = 1;
    repeat (3) @(negedge oclk);
    cmp++; if (bus.state !== 2'd0) begin err++; $display("FAIL reset_state got %0d want 0", bus.state); end
    cmp++; if (bus.fb_we !== 1'b0) begin err++; $display("FAIL reset_fb_we got %b want 0", bus.fb_we); end
    cmp++; if (bus.fb_raddr !== 13'd0) begin err++; $display("FAIL reset_raddr got %0d want 0", bus.fb_raddr); end
    cmp++; if (bus.color !== 16'hC020) begin err++; $display("FAIL reset_color got %h want c020", bus.color); end
    cmp++; if (bus.frame_cnt !== 8'd0) begin err++; $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt); end
    cmp++; if (bus.short_frame !== 1'b0) begin err++; $display("FAIL reset_short got %b want 0", bus.short_frame); end
    bus.cap_we_in = 0;
    rst = 0;
    @(negedge oclk);
  endtask

  task automatic test_display();
    bus.fb_rdata = 16'h1234;
    bus.x = 7'd10; bus.y = 7'd5;
    @(negedge oclk);
    cmp++; if (bus.fb_raddr !== 13'd805) begin err++; $display("FAIL raddr_10_5 got %0d want 805", bus.fb_raddr); end
    bus.x = 7'd0; bus.y = 7'd0;
    @(negedge oclk);
    cmp++; if (bus.fb_raddr !== 13'd0) begin err++; $display("FAIL raddr_0_0 got %0d want 0", bus.fb_raddr); end
    bus.x = 7'd59; bus.y = 7'd79;
    @(negedge oclk);
    cmp++; if (bus.fb_raddr !== 13'd4799) begin err++; $display("FAIL raddr_59_79 got %0d want 4799", bus.fb_raddr); end
    bus.x = 7'd0; bus.y = 7'd80;
    @(negedge oclk);
    cmp++; if (bus.fb_raddr !== 13'd0) begin err++; $display("FAIL raddr_y80 got %0d want 0", bus.fb_raddr); end
    bus.x = 7'd59; bus.y = 7'd79;
    repeat (3) @(negedge oclk);
    cmp++; if (bus.color !== 16'h1234) begin err++; $display("FAIL color_in_img got %h want 1234", bus.color); end
    bus.x = 7'd60; bus.y = 7'd0;
    @(negedge oclk);
    cmp++; if (bus.fb_raddr !== 13'd0) begin err++; $display("FAIL raddr_x60 got %0d want 0", bus.fb_raddr); end
    @(negedge oclk);
    cmp++; if (bus.color !== 16'h1234) begin err++; $display("FAIL color_latency2 got %h want 1234", bus.color); end
    @(negedge oclk);
    cmp++; if (bus.color !== 16'hC020) begin err++; $display("FAIL color_bg got %h want c020", bus.color); end
  endtask

  task automatic test_capture();
    bus.cfg_done = 1;
    repeat (2) @(negedge oclk);
    cmp++; if (bus.state !== 2'd1) begin err++; $display("FAIL arm_state got %0d want 1", bus.state); end
    writes(4800, wcnt);
    cmp++; if (wcnt !== 0) begin err++; $display("FAIL pre_fs_writes got %0d want 0", wcnt); end
    vsync();
    cmp++; if (bus.state !== 2'd2) begin err++; $display("FAIL capture_state got %0d want 2", bus.state); end
    writes(4800, wcnt);
    cmp++; if (wcnt !== 4800) begin err++; $display("FAIL capture_writes got %0d want 4800", wcnt); end
    vsync();
    cmp++; if (bus.frame_cnt !== 8'd1) begin err++; $display("FAIL frame_cnt1 got %0d want 1", bus.frame_cnt); end
    writes(4800, wcnt);
    vsync();
    cmp++; if (bus.frame_cnt !== 8'd2) begin err++; $display("FAIL frame_cnt2 got %0d want 2", bus.frame_cnt); end
    cmp++; if (bus.short_frame !== 1'b0) begin err++; $display("FAIL short_full got %b want 0", bus.short_frame); end
    cmp++; if (bus.state !== 2'd2) begin err++; $display("FAIL still_capture got %0d want 2", bus.state); end
  endtask

  task automatic test_freeze();
    int a, b;
    writes(2400, a);
    bus.freeze = 1;
    writes(2400, b);
    cmp++; if (a + b !== 4800) begin err++; $display("FAIL freeze_midframe_writes got %0d want 4800", a + b); end
    vsync();
    cmp++; if (bus.state !== 2'd3) begin err++; $display("FAIL frozen_state got %0d want 3", bus.state); end
    cmp++; if (bus.frame_cnt !== 8'd3) begin err++; $display("FAIL freeze_frame_cnt got %0d want 3", bus.frame_cnt); end
    writes(100, wcnt);
    cmp++; if (wcnt !== 0) begin err++; $display("FAIL frozen_writes got %0d want 0", wcnt); end
    bus.freeze = 0;
    vsync();
    cmp++; if (bus.state !== 2'd1) begin err++; $display("FAIL unfreeze_arm got %0d want 1", bus.state); end
    vsync();
    cmp++; if (bus.state !== 2'd2) begin err++; $display("FAIL unfreeze_capture got %0d want 2", bus.state); end
    cmp++; if (bus.frame_cnt !== 8'd3) begin err++; $display("FAIL arm_no_count got %0d want 3", bus.frame_cnt); end
  endtask

  task automatic test_snap();
    bus.freeze = 1;
    writes(4800, wcnt);
    vsync();
    writes(10, wcnt);
    vsync();
    cmp++; if (bus.state !== 2'd3) begin err++; $display("FAIL frozen_hold got %0d want 3", bus.state); end
    cmp++; if (bus.frame_cnt !== 8'd4) begin err++; $display("FAIL pre_snap_cnt got %0d want 4", bus.frame_cnt); end
    bus.snap = 1;
    @(negedge oclk);
    bus.snap = 0;
    bus.freeze = 0;
    @(negedge oclk);
    cmp++; if (bus.state !== 2'd1) begin err++; $display("FAIL snap_arm got %0d want 1", bus.state); end
    vsync();
    writes(4800, wcnt);
    cmp++; if (wcnt !== 4800) begin err++; $display("FAIL snap_writes got %0d want 4800", wcnt); end
    vsync();
    cmp++; if (bus.state !== 2'd3) begin err++; $display("FAIL snap_frozen got %0d want 3", bus.state); end
    cmp++; if (bus.frame_cnt !== 8'd5) begin err++; $display("FAIL snap_cnt got %0d want 5", bus.frame_cnt); end
    writes(50, wcnt);
    cmp++; if (wcnt !== 0) begin err++; $display("FAIL after_snap_writes got %0d want 0", wcnt); end
  endtask

  task automatic test_snap_fs();
    bus.cam_vsync = 1;
    repeat (3) @(negedge oclk);
    bus.snap = 1;
    @(negedge oclk);
    bus.snap = 0;
    cmp++; if (bus.state !== 2'd1) begin err++; $display("FAIL snap_fs_arm got %0d want 1", bus.state); end
    @(negedge oclk);
    bus.cam_vsync = 0;
    repeat (4) @(negedge oclk);
    vsync();
    cmp++; if (bus.state !== 2'd2) begin err++; $display("FAIL snap_fs_capture got %0d want 2", bus.state); end
    writes(4800, wcnt);
    vsync();
    cmp++; if (bus.state !== 2'd3) begin err++; $display("FAIL snap_fs_frozen got %0d want 3", bus.state); end
    cmp++; if (bus.frame_cnt !== 8'd6) begin err++; $display("FAIL snap_fs_cnt got %0d want 6", bus.frame_cnt); end
    vsync();
    vsync();
    cmp++; if (bus.state !== 2'd2) begin err++; $display("FAIL rearm_capture got %0d want 2", bus.state); end
  endtask

  task automatic test_short();
    writes(4700, wcnt);
    vsync();
    cmp++; if (bus.short_frame !== 1'b1) begin err++; $display("FAIL short_set got %b want 1", bus.short_frame); end
    cmp++; if (bus.frame_cnt !== 8'd7) begin err++; $display("FAIL short_cnt got %0d want 7", bus.frame_cnt); end
    writes(4800, wcnt);
    vsync();
    cmp++; if (bus.short_frame !== 1'b0) begin err++; $display("FAIL short_clear got %b want 0", bus.short_frame); end
    cmp++; if (bus.frame_cnt !== 8'd8) begin err++; $display("FAIL full_cnt got %0d want 8", bus.frame_cnt); end
  endtask

  task automatic test_cfg_drop();
    bus.cap_we_in = 1;
    #1;
    cmp++; if (bus.fb_we !== 1'b1) begin err++; $display("FAIL cfg_pre_we got %b want 1", bus.fb_we); end
    bus.cfg_done = 0;
    @(negedge oclk);
    cmp++; if (bus.state !== 2'd0) begin err++; $display("FAIL cfg_drop_state got %0d want 0", bus.state); end
    cmp++; if (bus.fb_we !== 1'b0) begin err++; $display("FAIL cfg_drop_we got %b want 0", bus.fb_we); end
    bus.cap_we_in = 0;
  endtask

  task automatic test_reset_mid();
    bus.cfg_done = 1;
    repeat (2) @(negedge oclk);
    vsync();
    bus.cap_we_in = 1;
    #1;
    cmp++; if (bus.fb_we !== 1'b1) begin err++; $display("FAIL mid_pre_we got %b want 1", bus.fb_we); end
    rst = 1;
    #1;
    cmp++; if (bus.fb_we !== 1'b0) begin err++; $display("FAIL mid_rst_we got %b want 0", bus.fb_we); end
    @(negedge oclk);
    cmp++; if (bus.state !== 2'd0) begin err++; $display("FAIL mid_rst_state got %0d want 0", bus.state); end
    cmp++; if (bus.frame_cnt !== 8'd0) begin err++; $display("FAIL mid_rst_cnt got %0d want 0", bus.frame_cnt); end
    bus.cap_we_in = 0;
    rst = 0;
    @(negedge oclk);
  endtask

  task automatic test_wrap();
    repeat (2) @(negedge oclk);
    vsync();
    cmp++; if (bus.state !== 2'd2) begin err++; $display("FAIL wrap_capture got %0d want 2", bus.state); end
    for (int i = 0; i < 255; i++) vsync();
    cmp++; if (bus.frame_cnt !== 8'd255) begin err++; $display("FAIL wrap_255 got %0d want 255", bus.frame_cnt); end
    vsync();
    cmp++; if (bus.frame_cnt !== 8'd0) begin err++; $display("FAIL wrap_0 got %0d want 0", bus.frame_cnt); end
    cmp++; if (bus.short_frame !== 1'b1) begin err++; $display("FAIL wrap_short got %b want 1", bus.short_frame); end
  endtask

  initial begin
    test_reset();
    test_display();
    test_capture();
    test_freeze();
    test_snap();
    test_snap_fs();
    test_short();
    test_cfg_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
